aes_round_ctrl: RTL
===================

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameters: none; round count fixed at 10 (AES-128).
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  plaintext/key offer.
REQ-005 in_ready  output  1  block can accept a new block.
REQ-006 in_data  input  128  plaintext.
REQ-007 in_key  input  128  cipher key (round-0 key).
REQ-008 out_valid  output  1  ciphertext available.
REQ-009 out_ready  input  1  consumer accepts ciphertext.
REQ-010 out_data  output  128  ciphertext.
REQ-011 busy  output  1  encryption in progress (ROUND or DONE).
REQ-012 dp_state  output  128  state to the external combinational round datapath.
REQ-013 dp_key  output  128  round key to the round datapath.
REQ-014 dp_final  output  1  final round; datapath skips MixColumns.
REQ-015 dp_result  input  128  round datapath result (combinational, same cycle).
REQ-016 kg_key  output  128  previous round key to the external key_generation unit.
REQ-017 kg_round  output  4  round index to key_generation (rcon select), 1..10.
REQ-018 kg_next  input  128  expanded round key from key_generation (combinational).

Function
REQ-019 FSM states: IDLE, ROUND, DONE; internal regs: state_reg[127:0], key_reg[127:0], round[3:0].
REQ-020 in_ready = 1 only in IDLE; in_valid ignored outside IDLE; no overlap of blocks.
REQ-021 IDLE, in_valid & in_ready at edge: state_reg <= in_data ^ in_key; key_reg <= in_key; round <= 1; -> ROUND.
REQ-022 ROUND combinational drive: dp_state = state_reg; kg_key = key_reg; kg_round = round; dp_key = kg_next; dp_final = (round == 10).
REQ-023 ROUND each edge: state_reg <= dp_result; key_reg <= kg_next; round < 10 -> round + 1, stay ROUND; round == 10 -> DONE.
REQ-024 Outside ROUND: dp_state, dp_key, kg_key = 0; kg_round = 0; dp_final = 0.
REQ-025 Latency: out_valid high immediately after the 10th rising edge following the accepting edge; exactly 10 ROUND cycles; one round per cycle.
REQ-026 DONE: out_valid = 1, out_data = state_reg; out_data = 0 whenever out_valid = 0.
REQ-027 Backpressure: DONE held, out_data stable, until out_valid & out_ready at an edge; then -> IDLE, round <= 0.
REQ-028 Simultaneous out handshake and in_valid in DONE: only output completes; new block acceptable from next cycle (in_ready rises after that edge).
REQ-029 busy = 1 in ROUND and DONE, 0 in IDLE.
REQ-030 round never exceeds 10; no wrap; values 11-15 unreachable.

Reset
REQ-031 rst_n low at an edge: FSM -> IDLE; state_reg, key_reg, round = 0; takes priority over all other events.
REQ-032 While rst_n low: in_ready = 0, out_valid = 0, busy = 0, out_data = 0, all dp_/kg_ outputs = 0.
REQ-033 Reset mid-ROUND or in DONE aborts the block; no out_valid produced for it; in_ready = 1 on the first cycle after rst_n returns high.

Verification
REQ-034 FIPS-197 C.1 (bench supplies reference round and key_generation): key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid 10 edges after accept.
REQ-035 Team vector: key 5468617473206d79204b756e67204675, pt 54776f204f6e65204e696e652054776f -> 29c3505f571420f6402299b31a02d73a; kg_round observed 1..10 in order; dp_final high only at round 10.
REQ-036 Backpressure: out_ready low 5 cycles after out_valid -> out_valid and out_data stable throughout, in_ready = 0, in_valid ignored; accept on out_ready -> IDLE next cycle.
REQ-037 Back-to-back: in_valid held high with two blocks, out_ready tied high -> both ciphertexts correct, second accepted the cycle after first output handshake; 12-cycle spacing between out_valid pulses.
REQ-038 Reset mid-operation: rst_n low at round 5 for 1 cycle -> no out_valid, all outputs 0 during reset, in_ready = 1 after release; next block encrypts correctly.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// ============================================================================
// aes_round_ctrl : AES-128 round sequencer driving external round/key datapaths
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_round_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [127:0] dp_state,
    output logic [127:0] dp_key,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic [127:0] kg_key,
    output logic [3:0]   kg_round,
    input  logic [127:0] kg_next
);

    localparam logic [3:0] C_LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_reg_q;
    logic [127:0] key_reg_q;
    logic [3:0]   round_q;

    logic         w_in_round;
    logic         w_in_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= S_IDLE;
            state_reg_q <= '0;
            key_reg_q   <= '0;
            round_q     <= '0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_reg_q <= in_data ^ in_key;
                        key_reg_q   <= in_key;
                        round_q     <= 4'd1;
                        fsm_q       <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_reg_q <= dp_result;
                    key_reg_q   <= kg_next;
                    // round saturates at 10; DONE keeps it until the handshake
                    if (round_q == C_LAST_ROUND) begin
                        fsm_q <= S_DONE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        fsm_q   <= S_IDLE;
                        round_q <= '0;
                    end
                end
                default: begin
                    fsm_q <= S_IDLE;
                end
            endcase
        end
    end

    // Every output is gated by rst_n so the block is silent while reset is held
    assign w_in_round = rst_n && (fsm_q == S_ROUND);
    assign w_in_done  = rst_n && (fsm_q == S_DONE);

    assign in_ready  = rst_n && (fsm_q == S_IDLE);
    assign out_valid = w_in_done;
    assign out_data  = w_in_done ? state_reg_q : '0;
    assign busy      = w_in_round || w_in_done;

    assign dp_state  = w_in_round ? state_reg_q : '0;
    assign dp_key    = w_in_round ? kg_next     : '0;
    assign dp_final  = w_in_round && (round_q == C_LAST_ROUND);
    assign kg_key    = w_in_round ? key_reg_q   : '0;
    assign kg_round  = w_in_round ? round_q     : 4'd0;

endmodule

`default_nettype wire
